// File: rtl/burst_ram_master_if.sv
// Cache-side request/response plus burst RAM command/data signals of burst_ram_master.
// master: the burst_ram_master view; slave: the cache controller and RAM side.
interface burst_ram_master_if #(
   parameter int AddressBitWidth = 4,
   parameter int DataBitWidth    = 64,
   parameter int BurstDataCount  = 4
);
   localparam int LineBitWidth     = DataBitWidth * BurstDataCount;
   localparam int LineAddrBitWidth = AddressBitWidth - $clog2(BurstDataCount);

   logic                          req_valid;
   logic                          req_ready;
   logic                          req_write;
   logic [LineAddrBitWidth-1:0]   req_addr;
   logic [LineBitWidth-1:0]       req_wr_line;
   logic                          resp_valid;
   logic                          resp_ready;
   logic                          resp_write;
   logic [LineBitWidth-1:0]       resp_rd_line;
   logic                          ram_cmd;
   logic                          ram_cmd_en;
   logic [AddressBitWidth-1:0]    ram_addr;
   logic [DataBitWidth-1:0]       ram_wr_data;
   logic [DataBitWidth/8-1:0]     ram_data_mask;
   logic [DataBitWidth-1:0]       ram_rd_data;
   logic                          ram_rd_data_valid;
   logic                          ram_init_calib;
   logic                          ram_busy;

   modport master (
      input  req_valid, req_write, req_addr, req_wr_line, resp_ready,
      input  ram_rd_data, ram_rd_data_valid, ram_init_calib, ram_busy,
      output req_ready, resp_valid, resp_write, resp_rd_line,
      output ram_cmd, ram_cmd_en, ram_addr, ram_wr_data, ram_data_mask
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wr_line, resp_ready,
      output ram_rd_data, ram_rd_data_valid, ram_init_calib, ram_busy,
      input  req_ready, resp_valid, resp_write, resp_rd_line,
      input  ram_cmd, ram_cmd_en, ram_addr, ram_wr_data, ram_data_mask
   );
endinterface

// File: rtl/burst_ram_master.sv
// Turns one cache line fill/writeback into a single burst RAM command; cmd_en one cycle after accept.
// req_ready only in Idle with RAM not busy; resp_valid held until resp_ready, one request in flight.
module burst_ram_master #(
   parameter int AddressBitWidth = 4,
   parameter int DataBitWidth    = 64,
   parameter int BurstDataCount  = 4
) (
   input logic                clk,
   input logic                rst,
   burst_ram_master_if.master bus
);
   localparam int LineBitWidth = DataBitWidth * BurstDataCount;
   localparam int CntBitWidth  = $clog2(BurstDataCount);
   localparam logic [CntBitWidth-1:0] LastCnt = CntBitWidth'(BurstDataCount - 1);

   localparam logic [2:0] WaitCalib = 3'd0;
   localparam logic [2:0] Idle      = 3'd1;
   localparam logic [2:0] Cmd       = 3'd2;
   localparam logic [2:0] WrData    = 3'd3;
   localparam logic [2:0] WrWait    = 3'd4;
   localparam logic [2:0] RdData    = 3'd5;
   localparam logic [2:0] Resp      = 3'd6;

   logic [2:0]              state;
   logic [CntBitWidth-1:0]  cnt;
   logic [CntBitWidth-1:0]  cnt_nxt;
   logic [LineBitWidth-1:0] wr_line;
   logic                    accept;

   assign bus.req_ready     = (state == Idle) && !bus.ram_busy;
   assign accept            = bus.req_valid && bus.req_ready;
   assign cnt_nxt           = cnt + CntBitWidth'(1);
   assign bus.ram_data_mask = '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= WaitCalib;
         cnt              <= '0;
         wr_line          <= '0;
         bus.ram_cmd_en   <= 1'b0;
         bus.ram_cmd      <= 1'b0;
         bus.ram_addr     <= '0;
         bus.ram_wr_data  <= '0;
         bus.resp_valid   <= 1'b0;
         bus.resp_write   <= 1'b0;
         bus.resp_rd_line <= '0;
      end else begin
         case (state)
            WaitCalib: begin
               if (bus.ram_init_calib) state <= Idle;
            end
            Idle: begin
               if (accept) begin
                  // Word 0 leaves with the command; the rest are shifted down one word per cycle.
                  wr_line         <= bus.req_wr_line >> DataBitWidth;
                  bus.ram_wr_data <= bus.req_wr_line[DataBitWidth-1:0];
                  bus.ram_cmd     <= bus.req_write;
                  bus.resp_write  <= bus.req_write;
                  bus.ram_addr    <= {bus.req_addr, CntBitWidth'(0)};
                  bus.ram_cmd_en  <= 1'b1;
                  state           <= Cmd;
               end
            end
            Cmd: begin
               bus.ram_cmd_en <= 1'b0;
               if (bus.ram_cmd) begin
                  bus.ram_wr_data <= wr_line[DataBitWidth-1:0];
                  wr_line         <= wr_line >> DataBitWidth;
                  cnt             <= CntBitWidth'(1);
                  state           <= WrData;
               end else begin
                  cnt   <= '0;
                  state <= RdData;
               end
            end
            WrData: begin
               if (cnt == LastCnt) begin
                  state <= WrWait;
               end else begin
                  bus.ram_wr_data <= wr_line[DataBitWidth-1:0];
                  wr_line         <= wr_line >> DataBitWidth;
                  cnt             <= cnt_nxt;
               end
            end
            WrWait: begin
               if (!bus.ram_busy) begin
                  bus.resp_valid <= 1'b1;
                  state          <= Resp;
               end
            end
            RdData: begin
               // Burst is counted in valid words, so gaps in ram_rd_data_valid just stretch it.
               if (bus.ram_rd_data_valid) begin
                  bus.resp_rd_line[cnt*DataBitWidth +: DataBitWidth] <= bus.ram_rd_data;
                  cnt <= cnt_nxt;
                  if (cnt == LastCnt) begin
                     bus.resp_valid <= 1'b1;
                     state          <= Resp;
                  end
               end
            end
            Resp: begin
               if (bus.resp_ready) begin
                  bus.resp_valid <= 1'b0;
                  state          <= Idle;
               end
            end
            default: state <= WaitCalib;
         endcase
      end
   end
endmodule

// File: tb/tb_burst_ram_master.sv
// Bench for burst_ram_master: scripted cache requests against a burst RAM model,
// with a response scoreboard checked by an independent monitor.
module tb_burst_ram_master;
   localparam int AW  = 4;
   localparam int DW  = 64;
   localparam int BC  = 4;
   localparam int LAW = 2;

   localparam logic [255:0] L2 = {64'h44, 64'h33, 64'h22, 64'h11};
   localparam logic [255:0] L0 = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                                  64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
   localparam logic [255:0] L3 = {64'hC0DE_0000_0000_000F, 64'hC0DE_0000_0000_000E,
                                  64'hC0DE_0000_0000_000D, 64'hC0DE_0000_0000_000C};

   typedef struct packed {
      logic         write;
      logic [3:0]   addr;
      logic [255:0] line;
   } cmd_t;

   typedef struct packed {
      logic         write;
      logic [255:0] line;
      int           lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   burst_ram_master_if #(.AddressBitWidth(AW), .DataBitWidth(DW), .BurstDataCount(BC)) bus ();

   burst_ram_master #(.AddressBitWidth(AW), .DataBitWidth(DW), .BurstDataCount(BC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int t_acc = 0;
   cmd_t cmd_q[$];
   exp_t exp_q[$];

   logic [63:0]  mem [16];
   int           rd_wait = 0, rd_left = 0, rd_ptr = 0, rd_sent = 0;
   int           gap_after = -1, gap_left = 0;
   int           busy_left = 0, wr_left = 0, wr_ptr = 0, wr_k = 0;
   logic [255:0] wr_exp = '0;
   bit           force_busy = 1'b0, stray = 1'b0;
   int           cmd_pulses = 0, cmd_expected = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_evt(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Burst RAM model: acts just after each rising edge.
   initial begin
      logic busy_prev;
      cmd_t c;
      bus.ram_busy = 1'b0;
      bus.ram_rd_data_valid = 1'b0;
      bus.ram_rd_data = '0;
      for (int i = 0; i < 16; i++) mem[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
      forever begin
         @(posedge clk);
         #1;
         busy_prev = bus.ram_busy;
         if (wr_left > 0) begin
            wr_k++;
            check("wr_data_word", bus.ram_wr_data, {192'b0, wr_exp[wr_k*64 +: 64]});
            mem[wr_ptr & 15] = bus.ram_wr_data;
            wr_ptr++;
            wr_left--;
         end
         bus.ram_rd_data_valid = 1'b0;
         bus.ram_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
         if (rd_wait > 0) begin
            rd_wait--;
         end else if (rd_left > 0) begin
            if (rd_sent == gap_after && gap_left > 0) begin
               gap_left--;
            end else begin
               bus.ram_rd_data_valid = 1'b1;
               bus.ram_rd_data = mem[rd_ptr & 15];
               rd_ptr++;
               rd_left--;
               rd_sent++;
            end
         end else if (stray) begin
            bus.ram_rd_data_valid = 1'b1;
            stray = 1'b0;
         end
         if (busy_left > 0) begin
            bus.ram_busy = 1'b1;
            busy_left--;
         end else begin
            bus.ram_busy = force_busy;
         end
         if (bus.ram_cmd_en) begin
            cmd_pulses++;
            check("cmd_gate_calib_busy", {254'b0, bus.ram_init_calib, busy_prev}, 256'b10);
            if (cmd_q.size() == 0) begin
               fail_evt("cmd_unexpected");
            end else begin
               c = cmd_q.pop_front();
               check("ram_cmd", {255'b0, bus.ram_cmd}, {255'b0, c.write});
               check("ram_addr", {252'b0, bus.ram_addr}, {252'b0, c.addr});
               if (c.write) begin
                  check("wr_data_word0", {192'b0, bus.ram_wr_data}, {192'b0, c.line[63:0]});
                  mem[c.addr] = bus.ram_wr_data;
                  wr_ptr = int'(c.addr) + 1;
                  wr_left = BC - 1;
                  wr_k = 0;
                  wr_exp = c.line;
               end else begin
                  rd_wait = 6;
                  rd_left = BC;
                  rd_ptr = int'(c.addr);
                  rd_sent = 0;
               end
            end
            bus.ram_busy = 1'b1;
            busy_left = 4;
         end
      end
   end

   // Response monitor: samples mid-low-phase, after stimulus has settled.
   initial begin
      bit prev_vld = 1'b0;
      logic held_w;
      logic [255:0] held_line;
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            prev_vld = 1'b0;
         end else begin
            if (bus.resp_valid) begin
               if (!prev_vld) begin
                  held_w = bus.resp_write;
                  held_line = bus.resp_rd_line;
                  if (exp_q.size() == 0) fail_evt("resp_unexpected");
                  else if (exp_q[0].lat > 0)
                     check("resp_latency", 256'(cyc - t_acc), 256'(exp_q[0].lat));
               end else begin
                  check("hold_resp_write", {255'b0, bus.resp_write}, {255'b0, held_w});
                  if (!held_w) check("hold_resp_line", bus.resp_rd_line, held_line);
                  check("req_ready_in_resp", {255'b0, bus.req_ready}, 256'b0);
               end
               if (bus.resp_ready && exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("resp_write", {255'b0, bus.resp_write}, {255'b0, e.write});
                  if (!e.write) check("resp_rd_line", bus.resp_rd_line, e.line);
               end
            end
            prev_vld = bus.resp_valid && !bus.resp_ready;
         end
      end
   end

   task automatic send(input bit w, input int la, input logic [255:0] line, input int lat);
      bit got = 1'b0;
      bus.req_write = w;
      bus.req_addr = LAW'(la);
      bus.req_wr_line = line;
      bus.req_valid = 1'b1;
      for (int t = 0; t < 300 && !got; t++) begin
         if (bus.req_ready) begin
            got = 1'b1;
            t_acc = cyc;
            cmd_q.push_back('{write: w, addr: 4'(la * BC), line: line});
            exp_q.push_back('{write: w, line: line, lat: lat});
            cmd_expected++;
         end
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      if (!got) fail_evt("accept_timeout");
   endtask

   task automatic wait_done();
      int t = 0;
      while ((exp_q.size() != 0 || cmd_q.size() != 0) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) fail_evt("completion_timeout");
      @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_cmd_en"}, {255'b0, bus.ram_cmd_en}, 256'b0);
      check({tag, "_ram_cmd"}, {255'b0, bus.ram_cmd}, 256'b0);
      check({tag, "_ram_addr"}, {252'b0, bus.ram_addr}, 256'b0);
      check({tag, "_wr_data"}, {192'b0, bus.ram_wr_data}, 256'b0);
      check({tag, "_mask"}, {248'b0, bus.ram_data_mask}, 256'b0);
      check({tag, "_resp_valid"}, {255'b0, bus.resp_valid}, 256'b0);
      check({tag, "_resp_write"}, {255'b0, bus.resp_write}, 256'b0);
      check({tag, "_resp_line"}, bus.resp_rd_line, 256'b0);
      check({tag, "_req_ready"}, {255'b0, bus.req_ready}, 256'b0);
   endtask

   initial begin
      int t;
      rst = 1'b1;
      bus.ram_init_calib = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr = '0;
      bus.req_wr_line = '0;
      bus.resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;

      // Calibration gate with a pending write
      bus.req_write = 1'b1;
      bus.req_addr = 2'd2;
      bus.req_wr_line = L2;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("gate_req_ready", {255'b0, bus.req_ready}, 256'b0);
         check("gate_cmd_en", {255'b0, bus.ram_cmd_en}, 256'b0);
      end
      bus.ram_init_calib = 1'b1;
      send(1'b1, 2, L2, 7);
      wait_done();
      check("single_cmd_pulse", 256'(cmd_pulses), 256'd1);

      // Read-back, preceded by a stray valid in Idle
      stray = 1'b1;
      repeat (2) @(negedge clk);
      send(1'b0, 2, L2, 12);
      wait_done();

      // Gapped read valid
      gap_after = 2;
      gap_left = 3;
      send(1'b0, 2, L2, 15);
      wait_done();
      gap_after = -1;

      // Busy in Idle blocks acceptance
      force_busy = 1'b1;
      repeat (2) @(negedge clk);
      bus.req_write = 1'b0;
      bus.req_addr = 2'd3;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("busy_req_ready", {255'b0, bus.req_ready}, 256'b0);
         check("busy_no_cmd", 256'(cmd_pulses), 256'(cmd_expected));
      end
      force_busy = 1'b0;

      // Response backpressure
      bus.resp_ready = 1'b0;
      send(1'b0, 3, L3, 12);
      t = 0;
      while (!bus.resp_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) fail_evt("resp_wait_timeout");
      repeat (5) @(negedge clk);
      bus.resp_ready = 1'b1;
      wait_done();

      // Back-to-back traffic
      send(1'b1, 0, L0, 7);
      send(1'b0, 3, L3, 12);
      send(1'b0, 0, L0, 12);
      wait_done();

      // Reset in the middle of a read burst
      rd_sent = 0;
      send(1'b0, 2, L2, 0);
      t = 0;
      while (rd_sent < 2 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) fail_evt("rd_progress_timeout");
      @(negedge clk);
      rst = 1'b1;
      bus.ram_init_calib = 1'b0;
      rd_left = 0;
      rd_wait = 0;
      busy_left = 0;
      wr_left = 0;
      cmd_q.delete();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      chk_reset("midrst");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("recal_resp_valid", {255'b0, bus.resp_valid}, 256'b0);
         check("recal_req_ready", {255'b0, bus.req_ready}, 256'b0);
      end
      bus.ram_init_calib = 1'b1;
      send(1'b0, 2, L2, 12);
      wait_done();

      check("total_cmd_pulses", 256'(cmd_pulses), 256'(cmd_expected));
      check("scoreboard_empty", 256'(exp_q.size()), 256'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
